// File: rtl/kyber_link_if.sv
// kyber_link_if
//   Stream handshake bundle between the Kyber bridge and its source and sink.
//   A transfer happens on every rising clk edge where valid && ready are both
//   high. valid never depends on ready. Data is stable while valid && !ready.
//   Parameter: DW - data word width.
//   slave  modport: the bridge side.
//                   Inputs are s_valid, s_data and m_ready.
//                   Outputs are s_ready, m_valid and m_data.
//   master modport: the side that drives words in and takes words out.
interface kyber_link_if #(
  parameter int DW = 32
);
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/kyber_link_bridge.sv
// kyber_link_bridge
//   Framed, buffered bridge for one Kyber public-key (pk) or ciphertext (c)
//   frame per request. The frame length in words is derived from k and DW.
//   A first-word-fall-through FIFO sits between source and sink.
//
//   Optional feature: macro KYBER_LINK_CSUM_EN.
//     When defined, csum holds the XOR checksum of the last delivered frame.
//     When undefined, csum is tied to 0.
//
//   Parameters
//     DW     data word width (32 or 64)
//     DEPTH  FIFO entries (power of two, >= 2)
//
//   Ports
//     clk, rst          clock, and asynchronous active-high reset
//     k                 Kyber rank 2/3/4, sampled when a request is accepted
//     req_pk, req_c     frame requests; pk wins when both are set
//     link              stream bundle (s_* in from the source, m_* out to the sink)
//     ready_pk/ready_c  1-cycle pulse when a frame has fully drained
//     busy              a frame is in progress
//     frame_err         1-cycle pulse: illegal k, or a request arriving while busy
//     csum              checksum of the last frame (0 without KYBER_LINK_CSUM_EN)
//     dbg_state         current FSM state (0 IDLE, 1 XFER, 2 DONE)
module kyber_link_bridge #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    k,
  input  logic          req_pk,
  input  logic          req_c,
  kyber_link_if.slave   link,
  output logic          ready_pk,
  output logic          ready_c,
  output logic          busy,
  output logic          frame_err,
  output logic [DW-1:0] csum,
  output logic [1:0]    dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = 10;  // longest frame is 392 words

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] in_cnt_q, out_cnt_q, len_q, len_req;
  logic          type_pk_q, req_pk_q, req_c_q, frame_err_q;
  logic          full, empty, push, pop;
  logic          accept, k_legal, req_any, req_rise, frame_err_d;

  // The frame byte count, converted to a count of DW-bit words.
  function automatic logic [CW-1:0] frame_len(input logic pk, input logic [2:0] kk);
    logic [15:0] bytes;
    logic [15:0] bits;
    bytes = 16'd0;
    case (kk)
      3'd2:    bytes = pk ? 16'd800  : 16'd768;
      3'd3:    bytes = pk ? 16'd1184 : 16'd1088;
      3'd4:    bytes = 16'd1568;
      default: bytes = 16'd0;
    endcase
    bits      = bytes << 3;
    frame_len = CW'(bits / 16'(DW));
  endfunction

  // The pointers carry one extra wrap bit, so that full and empty can be told apart.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // s_ready uses only the registered full flag.
  // As a result, a slot freed by a pop becomes usable in the next cycle.
  assign link.s_ready = (state_q == S_XFER) && !full && (in_cnt_q < len_q);
  assign link.m_valid = !empty;
  assign link.m_data  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign push         = link.s_valid && link.s_ready;
  assign pop          = link.m_valid && link.m_ready;

  assign k_legal  = (k == 3'd2) || (k == 3'd3) || (k == 3'd4);
  assign req_any  = req_pk || req_c;
  // A request raised during a frame is reported only on its rising edge.
  // A request held over from acceptance is therefore not an error.
  assign req_rise = (req_pk && !req_pk_q) || (req_c && !req_c_q);
  assign len_req  = frame_len(req_pk, k);

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          if (k_legal) begin
            accept  = 1'b1;
            state_d = S_XFER;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      S_XFER: begin
        frame_err_d = req_rise;
        if (pop && (out_cnt_q == len_q - CW'(1))) state_d = S_DONE;
      end
      S_DONE: begin
        frame_err_d = req_rise;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      len_q       <= '0;
      type_pk_q   <= 1'b0;
      req_pk_q    <= 1'b0;
      req_c_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_pk_q    <= req_pk;
      req_c_q     <= req_c;
      frame_err_q <= frame_err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (accept) begin
        type_pk_q <= req_pk;
        len_q     <= len_req;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (push) in_cnt_q  <= in_cnt_q + CW'(1);
        if (pop)  out_cnt_q <= out_cnt_q + CW'(1);
      end
    end
  end

  // The storage array needs no reset, because empty masks m_data.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= link.s_data;
  end

  assign busy      = (state_q == S_XFER) || (state_q == S_DONE);
  assign ready_pk  = (state_q == S_DONE) && type_pk_q;
  assign ready_c   = (state_q == S_DONE) && !type_pk_q;
  assign frame_err = frame_err_q;
  assign dbg_state = state_q;

`ifdef KYBER_LINK_CSUM_EN
  logic [DW-1:0] run_x_q, csum_q;

  // The final pop always lands in XFER.
  // So in the DONE cycle, run_x_q already holds the whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_x_q <= '0;
      csum_q  <= '0;
    end else begin
      if (accept)   run_x_q <= '0;
      else if (pop) run_x_q <= run_x_q ^ link.m_data;
      if (state_q == S_DONE) csum_q <= run_x_q;
    end
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif
endmodule

// File: tb/tb_kyber_link_bridge.sv
module tb_kyber_link_bridge;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    k;
  logic          req_pk, req_c;
  logic          ready_pk, ready_c, busy, frame_err;
  logic [DW-1:0] csum;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  kyber_link_if #(.DW(DW)) bif ();

  kyber_link_bridge #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .k         (k),
    .req_pk    (req_pk),
    .req_c     (req_c),
    .link      (bif),
    .ready_pk  (ready_pk),
    .ready_c   (ready_c),
    .busy      (busy),
    .frame_err (frame_err),
    .csum      (csum),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The frame length in words is computed from the byte counts.
  function automatic int model_len(input bit pk, input int kk);
    int bytes;
    if (pk) bytes = 384 * kk + 32;
    else if (kk == 2) bytes = 768;
    else if (kk == 3) bytes = 1088;
    else bytes = 1568;
    return bytes * 8 / DW;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_request(input bit p, input bit c, input logic [2:0] kk);
    req_pk = p;
    req_c  = c;
    k      = kk;
    @(posedge clk); #1;
    req_pk = 1'b0;
    req_c  = 1'b0;
    k      = 3'($urandom_range(7));  // k must be ignored after acceptance
  endtask

  // Drives one frame through the bridge while the scoreboard checks it.
  // stall:       number of cycles m_ready is held low at the start.
  // err_at:      cycle at which req_c is pulsed mid-frame (-1 = none).
  // abort_after: number of pops after which rst is asserted (0 = none).
  task automatic run_xfer(input int exp_len, input bit exp_pk, input int src_pct,
                          input int snk_pct, input int stall, input int err_at,
                          input int abort_after, input bit idx_data);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] xsum, w;
    int pushes = 0, pops = 0, bad = 0, pk_p = 0, c_p = 0, errs = 0;
    int pulse_cyc = -10, last_pop = -10;
    bit done = 0, aborted = 0;
    xsum = '0;
    for (int cyc = 0; cyc < 6000 && !done && !aborted; cyc++) begin
      if (abort_after != 0 && pops == abort_after) begin
        rst = 1'b1;
        bif.s_valid = 1'b0;
        bif.m_ready = 1'b0;
        #1;
        check("abort_m_valid", bif.m_valid, 0);
        check("abort_s_ready", bif.s_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_ready_c", ready_c, 0);
        check("abort_state", dbg_state, 0);
        aborted = 1;
      end else begin
        if (ready_pk) begin pk_p++; pulse_cyc = cyc; end
        if (ready_c)  begin c_p++;  pulse_cyc = cyc; end
        if (frame_err) errs++;
        if (cyc == pulse_cyc + 1) begin
          check("busy_after_done", busy, 0);
`ifdef KYBER_LINK_CSUM_EN
          check("csum", csum, xsum);
`else
          check("csum", csum, 0);
`endif
          done = 1;
        end else begin
          if (err_at >= 0 && cyc == err_at + 1) check("midframe_err", frame_err, 1);
          req_c = (err_at >= 0 && cyc == err_at);
          bif.m_ready = (cyc >= stall) && ($urandom_range(99) < snk_pct);
          bif.s_valid = ($urandom_range(99) < src_pct);
          bif.s_data  = idx_data ? DW'(pushes) : DW'({$urandom(), $urandom()});
          if (bif.m_valid && bif.m_ready) begin
            if (exp_q.size() == 0) bad++;
            else begin
              w = exp_q.pop_front();
              if (bif.m_data !== w) bad++;
            end
            xsum ^= bif.m_data;
            pops++;
            last_pop = cyc;
          end
          if (bif.s_valid && bif.s_ready) begin
            exp_q.push_back(bif.s_data);
            pushes++;
          end
          if (stall > DEPTH && cyc == stall - 1) begin
            check("stall_fill", pushes, DEPTH);
            check("stall_s_ready", bif.s_ready, 0);
          end
          @(posedge clk); #1;
        end
      end
    end
    bif.s_valid = 1'b0;
    bif.m_ready = 1'b0;
    req_c = 1'b0;
    if (abort_after != 0) begin
      check("abort_hit", aborted, 1);
    end else begin
      check("xfer_done", done, 1);
      check("data_order", bad, 0);
      check("word_count", pops, exp_len);
      check("push_count", pushes, exp_len);
      check("pulse_pk", pk_p, exp_pk ? 1 : 0);
      check("pulse_c", c_p, exp_pk ? 0 : 1);
      check("pulse_latency", pulse_cyc, last_pop + 1);
      check("err_count", errs, (err_at >= 0) ? 1 : 0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rq_pk;
    bit         rq_c;
    logic [2:0] kk;
    bit         exp_err;
    int         exp_len;
    bit         exp_pk;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst = 1'b1;
    k = 3'd0; req_pk = 1'b0; req_c = 1'b0;
    bif.s_valid = 1'b0; bif.s_data = '0; bif.m_ready = 1'b0;

    vecs[0] = '{1, 0, 3'd2, 0, 200, 1};
    vecs[1] = '{0, 1, 3'd2, 0, 192, 0};
    vecs[2] = '{1, 0, 3'd3, 0, 296, 1};
    vecs[3] = '{0, 1, 3'd3, 0, 272, 0};
    vecs[4] = '{1, 0, 3'd4, 0, 392, 1};
    vecs[5] = '{0, 1, 3'd4, 0, 392, 0};
    vecs[6] = '{1, 1, 3'd3, 0, 296, 1};
    vecs[7] = '{0, 1, 3'd5, 1, 0, 0};
    vecs[8] = '{1, 0, 3'd0, 1, 0, 0};
    vecs[9] = '{1, 0, 3'd7, 1, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", bif.m_valid, 0);
    check("rst_s_ready", bif.s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", {ready_pk, ready_c}, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_csum", csum, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven frames and illegal requests.
    foreach (vecs[i]) begin
      do_request(vecs[i].rq_pk, vecs[i].rq_c, vecs[i].kk);
      if (vecs[i].exp_err) begin
        check("bad_k_err", frame_err, 1);
        check("bad_k_busy", busy, 0);
        check("bad_k_s_ready", bif.s_ready, 0);
        @(posedge clk); #1;
        check("bad_k_err_off", frame_err, 0);
        check("bad_k_busy2", busy, 0);
      end else begin
        check("accept_busy", busy, 1);
        check("accept_err", frame_err, 0);
        if (i == 0) run_xfer(vecs[i].exp_len, vecs[i].exp_pk, 100, 100, 0, -1, 0, 0);
        else run_xfer(vecs[i].exp_len, vecs[i].exp_pk, $urandom_range(50, 100),
                      $urandom_range(50, 100), 0, -1, 0, 0);
      end
    end

    // k=4 c frame, with the sink stalled for 40 cycles.
    do_request(0, 1, 3'd4);
    run_xfer(model_len(0, 4), 0, 100, 100, 40, -1, 0, 0);

    // k=3 pk frame, with req_c pulsed mid-frame.
    do_request(1, 0, 3'd3);
    run_xfer(model_len(1, 3), 1, 80, 80, 0, 30, 0, 0);

    // Reset after 50 words of a k=3 c frame, then a full frame.
    do_request(0, 1, 3'd3);
    run_xfer(model_len(0, 3), 0, 100, 100, 0, -1, 50, 0);
    @(posedge clk); #1;
    check("abort_hold_ready_c", ready_c, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_abort_ready_c", ready_c, 0);
    check("post_abort_busy", busy, 0);
    do_request(0, 1, 3'd3);
    run_xfer(model_len(0, 3), 0, 90, 90, 0, -1, 0, 0);

    // Index data, k=2 pk; the checksum is checked against an XOR over the words.
    do_request(1, 0, 3'd2);
    run_xfer(model_len(1, 2), 1, 100, 100, 0, -1, 0, 1);

    // Random frames, checked against the length model.
    for (int n = 0; n < 4; n++) begin
      bit pk;
      int kk;
      pk = 1'($urandom_range(1));
      kk = $urandom_range(2, 4);
      do_request(pk, !pk, 3'(kk));
      check("rand_accept", busy, 1);
      run_xfer(model_len(pk, kk), pk, $urandom_range(30, 100), $urandom_range(30, 100),
               0, -1, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
